// File: rtl/mem_pkg.sv
// Shared encodings for the load/store initiator: request type codes and FSM states.
package mem_pkg;

  localparam logic [2:0] EXT_LHU = 3'b000;
  localparam logic [2:0] EXT_LBU = 3'b001;
  localparam logic [2:0] EXT_LH  = 3'b010;
  localparam logic [2:0] EXT_LB  = 3'b011;
  localparam logic [2:0] EXT_LW  = 3'b100;

  localparam logic [1:0] SSZ_SB = 2'b00;
  localparam logic [1:0] SSZ_SH = 2'b01;
  localparam logic [1:0] SSZ_SW = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP_ERR
  } state_t;

endpackage

// File: rtl/mem_lane.sv
// Little-endian lane logic: sub-word load extraction/extension and store merge into a read word.
module mem_lane (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ext,
  input  logic [1:0]  ssize,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  import mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (ext)
      EXT_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      EXT_LBU: load_data = {24'h000000, byte_sel};
      EXT_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      EXT_LHU: load_data = {16'h0000, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merge_data = word;
    case (ssize)
      SSZ_SB: merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SSZ_SH: begin
        if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
        else            merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: one request at a time, word-aligned memory accesses, sub-word stores as RMW.
//   state     | meaning
//   IDLE      | ready for a request
//   RD        | word address on mem_addr, memory read in flight
//   CAP       | mem_rdata valid: extract load lane or merge store lane
//   WR        | mem_we high for one cycle with the final word
//   RESP_ERR  | rejected request, error response on the outputs
module mem_access_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ext,
  input  logic [1:0]  req_ssize,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);
  import mem_pkg::*;

  state_t state, state_nxt;

  logic        r_we;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic [2:0]  r_ext;
  logic [1:0]  r_ssize;

  logic        accept;
  logic        req_err;
  logic        req_sw;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_sw    = req_we && (req_ssize == SSZ_SW);
  assign mem_we    = (state == ST_WR);

  // Illegal encodings reject the request whatever its direction.
  always_comb begin
    req_err = 1'b0;
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH)) req_err = 1'b1;
    if (req_ext > EXT_LW)                      req_err = 1'b1;
    if (req_ssize == 2'b11)                    req_err = 1'b1;
    if (req_we) begin
      case (req_ssize)
        SSZ_SW:  if (req_addr[1:0] != 2'b00) req_err = 1'b1;
        SSZ_SH:  if (req_addr[0])            req_err = 1'b1;
        default: ;
      endcase
    end else begin
      case (req_ext)
        EXT_LW:         if (req_addr[1:0] != 2'b00) req_err = 1'b1;
        EXT_LH, EXT_LHU: if (req_addr[0])           req_err = 1'b1;
        default: ;
      endcase
    end
  end

  mem_lane u_lane (
    .word       (mem_rdata),
    .wdata      (r_wdata),
    .addr_lo    (r_addr_lo),
    .ext        (r_ext),
    .ssize      (r_ssize),
    .load_data  (lane_load),
    .merge_data (lane_merge)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)     state_nxt = ST_RESP_ERR;
          else if (req_sw) state_nxt = ST_WR;
          else             state_nxt = ST_RD;
        end
      end
      ST_RD:       state_nxt = ST_CAP;
      ST_CAP:      state_nxt = r_we ? ST_WR : ST_IDLE;
      ST_WR:       state_nxt = ST_IDLE;
      ST_RESP_ERR: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // The error response is registered at accept so it shows the cycle right after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      mem_addr  <= 32'h0;
      mem_wd    <= 32'h0;
      r_we      <= 1'b0;
      r_addr_lo <= 2'b00;
      r_wdata   <= 32'h0;
      r_ext     <= 3'b000;
      r_ssize   <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_we      <= req_we;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata;
            r_ext     <= req_ext;
            r_ssize   <= req_ssize;
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_sw) mem_wd <= req_wdata;
            end
          end
        end
        ST_CAP: begin
          if (r_we) begin
            mem_wd <= lane_merge;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= lane_load;
          end
        end
        ST_WR: rsp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand corner sequences, randomized model check.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ext;
  logic [1:0]  req_ssize;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DEPTH(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ext   (req_ext),
    .req_ssize (req_ssize),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Data memory: 1-cycle registered read, plus a backdoor port for preloading.
  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = 10'd0;
  logic [31:0] bd_data = 32'h0;

  always @(posedge clk) begin
    if (bd_we)       mem[bd_idx] <= bd_data;
    else if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
    mem_rdata <= mem[mem_addr[11:2]];
  end

  logic [31:0] ref_mem [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: response timing/data and store effect from the access rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ext, input logic [1:0] ssize,
                       output int cyc, output logic [31:0] rdata, output logic err,
                       output int wecnt, output logic [31:0] wd);
    int size;
    int sh;
    logic [63:0] mask;
    logic [31:0] w;
    logic [31:0] v;
    if (we) size = (ssize == 2) ? 4 : (ssize == 1) ? 2 : 1;
    else    size = (ext == 4) ? 4 : (ext == 2 || ext == 0) ? 2 : 1;
    err = (ext > 4) || (ssize == 3) || ((addr >> 2) >= 1024) || ((addr % size) != 0);
    rdata = 0; wd = 0; wecnt = 0;
    if (err) begin
      cyc = 1;
      return;
    end
    w = ref_mem[addr[7:2]];
    sh = 8 * int'(addr[1:0]);
    mask = ((64'd1 << (8 * size)) - 1) << sh;
    if (!we) begin
      cyc = 3;
      v = (w & mask[31:0]) >> sh;
      if ((ext == 3 && v[7]) || (ext == 2 && v[15])) v = v | ~32'(((64'd1 << (8 * size)) - 1));
      rdata = v;
    end else begin
      cyc = (size == 4) ? 2 : 4;
      wecnt = 1;
      wd = (w & ~mask[31:0]) | ((wdata << sh) & mask[31:0]);
      ref_mem[addr[7:2]] = wd;
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] ext, input logic [1:0] ssize, input logic hold,
                         output int rcyc, output logic [31:0] rdata, output logic rerr,
                         output int rcnt, output int wecnt, output int wecyc, output logic [31:0] wd);
    rcyc = -1; rdata = 0; rerr = 0; rcnt = 0; wecnt = 0; wecyc = -1; wd = 0;
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_ext = ext; req_ssize = ssize;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we) begin wecnt++; wecyc = c; wd = mem_wd; end
      if (rsp_valid) begin
        rcnt++;
        if (rcyc < 0) begin rcyc = c; rdata = rsp_rdata; rerr = rsp_err; end
      end
      if (hold && rcyc < 0) begin
        req_valid = 1; req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 0;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ext;
    logic [1:0]  ssize;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    int          wecyc;
    logic [31:0] wd;
  } vec_t;

  vec_t vt [11];

  initial begin
    int rcyc, rcnt, wecnt, wecyc, ecyc, ewecnt;
    logic [31:0] rdata, wd, erdata, ewd;
    logic rerr, eerr;
    logic we;
    logic [31:0] addr;
    logic [2:0] ext;
    logic [1:0] ssize;

    vt[0]  = '{"lb_0x11",   0, 32'h11,   32'h0,        3'b011, 2'b00, 3, 32'hFFFFFFAA, 0, -1, 32'h0};
    vt[1]  = '{"lhu_0x12",  0, 32'h12,   32'h0,        3'b000, 2'b00, 3, 32'h00008899, 0, -1, 32'h0};
    vt[2]  = '{"lh_0x12",   0, 32'h12,   32'h0,        3'b010, 2'b00, 3, 32'hFFFF8899, 0, -1, 32'h0};
    vt[3]  = '{"lbu_0x10",  0, 32'h10,   32'h0,        3'b001, 2'b00, 3, 32'h000000BB, 0, -1, 32'h0};
    vt[4]  = '{"sb_0x13",   1, 32'h13,   32'h55,       3'b000, 2'b00, 4, 32'h0,        0,  3, 32'h5599AABB};
    vt[5]  = '{"lw_0x10",   0, 32'h10,   32'h0,        3'b100, 2'b00, 3, 32'h5599AABB, 0, -1, 32'h0};
    vt[6]  = '{"err_lw_06", 0, 32'h06,   32'h0,        3'b100, 2'b00, 1, 32'h0,        1, -1, 32'h0};
    vt[7]  = '{"err_sh_11", 1, 32'h11,   32'h1234,     3'b000, 2'b01, 1, 32'h0,        1, -1, 32'h0};
    vt[8]  = '{"err_ext7",  0, 32'h10,   32'h0,        3'b111, 2'b00, 1, 32'h0,        1, -1, 32'h0};
    vt[9]  = '{"err_range", 0, 32'h1000, 32'h0,        3'b100, 2'b00, 1, 32'h0,        1, -1, 32'h0};
    vt[10] = '{"sw_0x20",   1, 32'h20,   32'hDEADBEEF, 3'b000, 2'b10, 2, 32'h0,        0,  1, 32'hDEADBEEF};

    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_ext = 0; req_ssize = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (i == 4) ? 32'h8899AABB : (32'h9E3779B9 * (i + 1));
      bd_we = 1; bd_idx = 10'(i); bd_data = ref_mem[i];
      @(posedge clk); #1;
    end
    bd_we = 0;
    @(posedge clk); #1;

    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wd",    mem_wd,   32'h0);
    chk("rst_mem_we",    {31'b0, mem_we},    32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // sh aborted by reset while in the read-capture phase.
    wecnt = 0; rcnt = 0;
    req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h7777; req_ext = 0; req_ssize = 2'b01;
    @(posedge clk); #1;
    req_valid = 0;
    if (mem_we) wecnt++;
    if (rsp_valid) rcnt++;
    @(posedge clk); #1;
    if (mem_we) wecnt++;
    if (rsp_valid) rcnt++;
    rst_n = 0;
    @(posedge clk); #1;
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'h0);
    chk("abort_rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("abort_mem_addr",  mem_addr, 32'h0);
    chk("abort_mem_wd",    mem_wd,   32'h0);
    chk("abort_mem_we",    {31'b0, mem_we},    32'd0);
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      if (mem_we) wecnt++;
      if (rsp_valid) rcnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_write", 32'(wecnt), 32'd0);
    chk("abort_no_rsp",   32'(rcnt),  32'd0);
    chk("abort_word_kept", mem[4], 32'h8899AABB);

    for (int i = 0; i < 11; i++) begin
      run_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].ext, vt[i].ssize, 1'b0,
              rcyc, rdata, rerr, rcnt, wecnt, wecyc, wd);
      model(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].ext, vt[i].ssize, ecyc, erdata, eerr, ewecnt, ewd);
      chk({vt[i].name, "_cyc"},   32'(rcyc), 32'(vt[i].cyc));
      chk({vt[i].name, "_rdata"}, rdata, vt[i].rdata);
      chk({vt[i].name, "_err"},   {31'b0, rerr}, {31'b0, vt[i].err});
      chk({vt[i].name, "_nrsp"},  32'(rcnt), 32'd1);
      chk({vt[i].name, "_wecnt"}, 32'(wecnt), (vt[i].wecyc > 0) ? 32'd1 : 32'd0);
      if (vt[i].wecyc > 0) begin
        chk({vt[i].name, "_wecyc"}, 32'(wecyc), 32'(vt[i].wecyc));
        chk({vt[i].name, "_wd"},    wd, vt[i].wd);
      end
    end

    // sw then lw to the same word accepted in the sw response cycle.
    req_valid = 1; req_we = 1; req_addr = 32'h24; req_wdata = 32'h12345678; req_ext = 0; req_ssize = 2'b10;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("b2b_sw_rsp",   {31'b0, rsp_valid}, 32'd1);
    chk("b2b_sw_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_we = 0; req_addr = 32'h24; req_ext = 3'b100; req_ssize = 2'b00;
    @(posedge clk); #1;
    req_valid = 0;
    rcyc = -1; rdata = 0;
    for (int c = 1; c <= 8; c++) begin
      if (rsp_valid && rcyc < 0) begin rcyc = c; rdata = rsp_rdata; end
      @(posedge clk); #1;
    end
    ref_mem[9] = 32'h12345678;
    chk("b2b_lw_cyc",   32'(rcyc), 32'd3);
    chk("b2b_lw_rdata", rdata, 32'h12345678);

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      addr = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 4095))) : 32'($urandom_range(0, 255));
      ext = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      ssize = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_req(we, addr, $urandom, ext, ssize, 1'($urandom), rcyc, rdata, rerr, rcnt, wecnt, wecyc, wd);
      model(we, addr, req_wdata_snap(), ext, ssize, ecyc, erdata, eerr, ewecnt, ewd);
      chk("rnd_cyc",   32'(rcyc), 32'(ecyc));
      chk("rnd_rdata", rdata, erdata);
      chk("rnd_err",   {31'b0, rerr}, {31'b0, eerr});
      chk("rnd_nrsp",  32'(rcnt), 32'd1);
      chk("rnd_wecnt", 32'(wecnt), 32'(ewecnt));
      if (ewecnt == 1) chk("rnd_wd", wd, ewd);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Store data actually presented at accept (run_req may scramble req_wdata afterwards).
  logic [31:0] wdata_at_accept;
  always @(posedge clk) if (req_valid && req_ready) wdata_at_accept <= req_wdata;

  function automatic logic [31:0] req_wdata_snap();
    return wdata_at_accept;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
